// File: rtl/program_counter.sv
// program_counter: 16-bit 6502 PC (PCL/PCH) with load, page-carry increment and tri-state bus drive.
// Optional build macro PC_WRAP_DETECT_EN enables the sticky pc_wrapped flag (tied low otherwise).
`default_nettype none

module program_counter #(
  parameter logic [15:0] RESET_PC = 16'hFFFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  adl_in,
  input  logic [7:0]  adh_in,
  input  logic        load_pcl,
  input  logic        load_pch,
  input  logic        pc_inc,
  input  logic        pcl_to_adl,
  input  logic        pch_to_adh,
  input  logic        pcl_to_db,
  input  logic        pch_to_db,
  output logic [7:0]  adl_out,
  output logic [7:0]  adh_out,
  output logic [7:0]  db_out,
  output logic [15:0] pc_out,
  output logic        page_cross,
  output logic        db_conflict,
  output logic        pc_wrapped
);

  logic [7:0]  pcl;
  logic [7:0]  pch;
  logic [7:0]  sel_l;
  logic [7:0]  sel_h;
  logic [15:0] sel_pc;
  logic [15:0] next_pc;
  logic        carry_out;

  // Loaded bytes replace the held ones before the increment, so load+inc yields target+1.
  assign sel_l     = load_pcl ? adl_in : pcl;
  assign sel_h     = load_pch ? adh_in : pch;
  assign sel_pc    = {sel_h, sel_l};
  assign next_pc   = sel_pc + {15'd0, pc_inc};
  assign carry_out = pc_inc & (sel_l == 8'hFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcl        <= RESET_PC[7:0];
      pch        <= RESET_PC[15:8];
      page_cross <= 1'b0;
    end else begin
      pcl        <= next_pc[7:0];
      pch        <= next_pc[15:8];
      page_cross <= carry_out;
    end
  end

`ifdef PC_WRAP_DETECT_EN
  logic wrapped_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrapped_q <= 1'b0;
    end else if (pc_inc && (sel_pc == 16'hFFFF)) begin
      wrapped_q <= 1'b1;
    end
  end

  assign pc_wrapped = wrapped_q;
`else
  assign pc_wrapped = 1'b0;
`endif

  assign pc_out = {pch, pcl};

  // PCL has priority on the internal data bus when both byte enables are high.
  assign adl_out     = pcl_to_adl ? pcl : 8'bz;
  assign adh_out     = pch_to_adh ? pch : 8'bz;
  assign db_out      = pcl_to_db ? pcl : (pch_to_db ? pch : 8'bz);
  assign db_conflict = pcl_to_db & pch_to_db;

endmodule

`default_nettype wire

// File: tb/tb_program_counter.sv
// tb_program_counter: directed and randomized checks of program_counter against an arithmetic PC model.
`default_nettype none

module tb_program_counter;

  localparam logic [15:0] RESET_PC = 16'hFFFC;

  logic        clk;
  logic        reset;
  logic [7:0]  adl_in;
  logic [7:0]  adh_in;
  logic        load_pcl;
  logic        load_pch;
  logic        pc_inc;
  logic        pcl_to_adl;
  logic        pch_to_adh;
  logic        pcl_to_db;
  logic        pch_to_db;
  tri0  [7:0]  adl_out;
  tri0  [7:0]  adh_out;
  tri0  [7:0]  db_out;
  logic [15:0] pc_out;
  logic        page_cross;
  logic        db_conflict;
  logic        pc_wrapped;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: the PC as a plain integer plus the two flags.
  int m_pc;
  bit m_cross;
  bit m_wrap;

  program_counter #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .adl_in(adl_in), .adh_in(adh_in),
    .load_pcl(load_pcl), .load_pch(load_pch), .pc_inc(pc_inc),
    .pcl_to_adl(pcl_to_adl), .pch_to_adh(pch_to_adh),
    .pcl_to_db(pcl_to_db), .pch_to_db(pch_to_db),
    .adl_out(adl_out), .adh_out(adh_out), .db_out(db_out),
    .pc_out(pc_out), .page_cross(page_cross),
    .db_conflict(db_conflict), .pc_wrapped(pc_wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pc    = int'(RESET_PC);
    m_cross = 1'b0;
    m_wrap  = 1'b0;
  endtask

  // Advance the model by one edge using the controls currently applied.
  task automatic model_edge();
    int base;
    int hi;
    int lo;
    int sum;
    hi   = load_pch ? int'(adh_in) : (m_pc >> 8);
    lo   = load_pcl ? int'(adl_in) : (m_pc & 255);
    base = hi * 256 + lo;
    sum  = base + (pc_inc ? 1 : 0);
    m_cross = ((sum >> 8) != (base >> 8));
`ifdef PC_WRAP_DETECT_EN
    if (sum == 65536) m_wrap = 1'b1;
`endif
    m_pc = sum % 65536;
  endtask

  // Undriven buses read as zero through the tb pulldown nets.
  task automatic check_outputs(input string tag);
    logic [7:0] exp_db;
    exp_db = pcl_to_db ? 8'(m_pc & 255) : (pch_to_db ? 8'(m_pc >> 8) : 8'h00);
    check({tag, ".pc"},       32'(pc_out),      32'(m_pc));
    check({tag, ".cross"},    32'(page_cross),  32'(m_cross));
    check({tag, ".wrap"},     32'(pc_wrapped),  32'(m_wrap));
    check({tag, ".adl"},      32'(adl_out),     pcl_to_adl ? 32'(m_pc & 255) : 32'h0);
    check({tag, ".adh"},      32'(adh_out),     pch_to_adh ? 32'(m_pc >> 8) : 32'h0);
    check({tag, ".db"},       32'(db_out),      32'(exp_db));
    check({tag, ".conflict"}, 32'(db_conflict), 32'(pcl_to_db & pch_to_db));
  endtask

  task automatic set_ctl(input bit ll, input logic [7:0] al, input bit lh,
                         input logic [7:0] ah, input bit inc);
    load_pcl = ll; adl_in = al; load_pch = lh; adh_in = ah; pc_inc = inc;
  endtask

  task automatic set_oe(input bit a, input bit b, input bit c, input bit d);
    pcl_to_adl = a; pch_to_adh = b; pcl_to_db = c; pch_to_db = d;
  endtask

  // Controls are applied at the falling edge; results are sampled at the next falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic load_pc(input logic [15:0] v);
    set_ctl(1'b1, v[7:0], 1'b1, v[15:8], 1'b0);
    cycle("load");
  endtask

  initial begin
    reset = 1'b1;
    set_ctl(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    set_oe(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #2;
    check_outputs("in_reset");
    @(negedge clk);
    reset = 1'b0;
    cycle("post_reset0");
    cycle("post_reset1");

    // Page carry on increment.
    load_pc(16'h10FE);
    set_ctl(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cycle("inc_10ff");
    check("inc_10ff.exact", 32'(pc_out), 32'h10FF);
    cycle("inc_1100");
    check("inc_1100.exact", 32'(pc_out), 32'h1100);
    check("inc_1100.cross", 32'(page_cross), 32'h1);
    cycle("inc_1101");
    check("inc_1101.cross", 32'(page_cross), 32'h0);

    // Loads with and without increment.
    set_ctl(1'b1, 8'h34, 1'b1, 8'h12, 1'b0);
    cycle("ld_1234");
    check("ld_1234.exact", 32'(pc_out), 32'h1234);
    set_ctl(1'b1, 8'h34, 1'b1, 8'h12, 1'b1);
    cycle("ldinc_1235");
    check("ldinc_1235.exact", 32'(pc_out), 32'h1235);
    set_ctl(1'b1, 8'hFF, 1'b1, 8'h12, 1'b1);
    cycle("ldinc_1300");
    check("ldinc_1300.exact", 32'(pc_out), 32'h1300);
    check("ldinc_1300.cross", 32'(page_cross), 32'h1);

    // Bus drive and conflict.
    load_pc(16'hABCD);
    set_ctl(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    set_oe(1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    check("drive.adl", 32'(adl_out), 32'hCD);
    check("drive.adh", 32'(adh_out), 32'hAB);
    check("drive.db", 32'(db_out), 32'hCD);
    check("drive.conflict", 32'(db_conflict), 32'h1);
    set_oe(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check("drive.db_pch", 32'(db_out), 32'hAB);
    check("drive.noconflict", 32'(db_conflict), 32'h0);
    // Drive old value while loading a new one.
    set_oe(1'b1, 1'b1, 1'b0, 1'b0);
    set_ctl(1'b1, 8'h55, 1'b1, 8'h66, 1'b0);
    #1;
    check("drive_old.adl", 32'(adl_out), 32'hCD);
    cycle("drive_new");
    set_oe(1'b0, 1'b0, 1'b0, 1'b0);

    // Wrap from 0xFFFF and sticky flag.
    load_pc(16'hFFFF);
    set_ctl(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cycle("wrap");
    check("wrap.exact", 32'(pc_out), 32'h0000);
    check("wrap.cross", 32'(page_cross), 32'h1);
    cycle("wrap_sticky0");
    cycle("wrap_sticky1");

    // Asynchronous reset mid-cycle with a load and increment pending.
    set_ctl(1'b1, 8'h77, 1'b1, 8'h88, 1'b1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async.pc_now", 32'(pc_out), 32'(RESET_PC));
    check("async.wrap_now", 32'(pc_wrapped), 32'h0);
    cycle("async_hold");
    @(negedge clk);
    reset = 1'b0;
    set_ctl(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cycle("async_release");

    // Randomized traffic, biased toward page and wrap boundaries.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] al;
      logic [7:0] ah;
      al = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      ah = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      set_ctl(1'($urandom_range(0, 3) == 0), al, 1'($urandom_range(0, 3) == 0), ah,
              1'($urandom_range(0, 2) != 0));
      set_oe(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/program_counter.md
Name: program_counter

Overview:
16-bit 6502 program counter (PCL/PCH), directly downstream of the input data latch. Captures jump/branch/vector targets from the ADL and ADH buses that the latch drives. Supports increment with page carry. Drives the current PC back onto ADL, ADH and the internal data bus through tri-state enables, for address generation and stack pushes.

Parameters:
RESET_PC, 16'hFFFC, PC value forced by reset (reset-vector fetch address)

Ports:
clk  input  1  single system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
adl_in  input  8  address bus low, source for PCL load
adh_in  input  8  address bus high, source for PCH load
load_pcl  input  1  select adl_in as PCL source this cycle
load_pch  input  1  select adh_in as PCH source this cycle
pc_inc  input  1  increment selected PC value by 1 this cycle
pcl_to_adl  input  1  drive PCL onto adl_out
pch_to_adh  input  1  drive PCH onto adh_out
pcl_to_db  input  1  drive PCL onto db_out
pch_to_db  input  1  drive PCH onto db_out
adl_out  output  8  tri-state ADL drive
adh_out  output  8  tri-state ADH drive
db_out  output  8  tri-state internal data bus drive
pc_out  output  16  current {PCH,PCL}, always driven (debug/trace)
page_cross  output  1  registered 1-cycle pulse: carry propagated into PCH
db_conflict  output  1  combinational: pcl_to_db and pch_to_db both high
pc_wrapped  output  1  sticky wrap flag (see Optional Feature)

Behaviour:
- Reset (async, active-high): PCL=RESET_PC[7:0], PCH=RESET_PC[15:8], page_cross=0, pc_wrapped=0. Takes effect immediately and holds while asserted. Reset mid-increment or mid-load discards the pending update.
- Source select each edge: sel_l = load_pcl ? adl_in : PCL; sel_h = load_pch ? adh_in : PCH.
- Next state:
  - {PCH,PCL} <= {sel_h,sel_l} + pc_inc, 16-bit, wrapping modulo 2^16.
  - Load and increment in the same cycle are legal: the loaded value is incremented (6502 behaviour). Example: load 0x12 with inc gives PCL=0x13.
  - Carry into high byte only when pc_inc=1 and sel_l==8'hFF. PCL becomes 0x00 and PCH becomes sel_h+1. With load_pch, the carry applies to adh_in.
  - No load and no inc: hold.
- page_cross <= pc_inc & (sel_l==8'hFF). Cleared the following cycle unless re-triggered.
- Latency: loads and increments are visible on pc_out and all bus outputs one edge after the control is sampled. Bus outputs are combinational from registers, with zero additional delay.
- Tri-state outputs:
  - adl_out = pcl_to_adl ? PCL : 8'bz
  - adh_out = pch_to_adh ? PCH : 8'bz
  - db_out = pcl_to_db ? PCL : (pch_to_db ? PCH : 8'bz). PCL wins on conflict.
- db_conflict = pcl_to_db & pch_to_db. Purely combinational; it does not affect state.
- Output enables never alter PC state. Driving and loading in the same cycle drives the old value and loads the new one at the edge.
- Controls are sampled only at the rising edge. X/Z on adl_in/adh_in is irrelevant when the corresponding load is low.

Optional Feature:
PC_WRAP_DETECT_EN
- Defined: pc_wrapped is set on the edge where pc_inc=1 and {sel_h,sel_l}==16'hFFFF (result 0x0000). It is sticky until reset.
- Undefined: pc_wrapped is tied to 0 and the detection logic is absent. The port remains, so the interface is identical.
- All other behaviour is unchanged in both builds.

Test Plan:
- Reset with RESET_PC=16'hFFFC, then release and hold 2 cycles -> pc_out=16'hFFFC, page_cross=0, all tri-state outputs Z.
- From PC=0x10FE, pc_inc for 3 cycles -> 0x10FF, 0x1100 (page_cross=1 that cycle only), 0x1101.
- load_pcl=1 with adl_in=0x34 and load_pch=1 with adh_in=0x12, pc_inc=0 -> pc_out=0x1234. The same with pc_inc=1 -> 0x1235. With adl_in=0xFF, adh_in=0x12 and inc -> 0x1300 and page_cross=1.
- PC=0xABCD, assert pcl_to_adl and pch_to_adh -> adl_out=0xCD, adh_out=0xAB. Assert both pcl_to_db and pch_to_db -> db_out=0xCD, db_conflict=1.
- PC=0xFFFF, pc_inc -> pc_out=0x0000, page_cross=1. pc_wrapped=1 if PC_WRAP_DETECT_EN is defined, else 0. pc_wrapped persists through further increments until reset.
- Assert reset asynchronously mid-cycle during pc_inc with a load pending -> pc_out=RESET_PC immediately, no update at the next edge while reset is high.
